// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the 5-stage MIPS core.
// Sits beside ID and produces:
//   - forwardSignal : ID-stage forwarding selects for the branch comparator
//                     ([3:2] Rs, [1:0] Rt; 00 regfile, 01 EX/MEM aluout, 10 WB value)
//   - stall         : hold PC and IF/ID, zero ID control outputs
//   - stall_EX      : hold ID/EX and EX while the divider runs
//   - bubble_MEM    : load zeros into EX/MEM while EX is held
//   - flush         : clear IF/ID, ID/EX, EX/MEM on an exception from MEM
//   - div_busy      : divider sequencer is in BUSY
//   - div_done      : divider result valid (HI/LO write enable)
// Inputs: clk, rst (sync, active-high), ID operand fields and branch/jump flags,
// write-back controls/destinations of EX, MEM and WB, EX_div_start, exc_valid.
module hazard_ctrl #(
   parameter int DIV_CYCLES = 32,
   parameter int CNT_W      = 6
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] ID_Rs,
   input  logic [4:0] ID_Rt,
   input  logic       ID_Beq,
   input  logic       ID_JumpV,
   input  logic       ID_EX_RegWrite,
   input  logic       ID_EX_Mem2Reg,
   input  logic [4:0] ID_EX_Rd,
   input  logic       EX_MEM_RegWrite,
   input  logic       EX_MEM_Mem2Reg,
   input  logic [4:0] EX_MEM_Rd,
   input  logic       MEM_WB_RegWrite,
   input  logic [4:0] MEM_WB_Rd,
   input  logic       EX_div_start,
   input  logic       exc_valid,
   output logic [3:0] forwardSignal,
   output logic       stall,
   output logic       stall_EX,
   output logic       bubble_MEM,
   output logic       flush,
   output logic       div_busy,
   output logic       div_done
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 1);

   logic [0:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             dstall;
   logic             done_raw;
   logic             hz;

   // Register 0 is hard-wired, so it never creates a dependency.
   function automatic logic reg_match(input logic [4:0] d, input logic [4:0] x);
      return (d != 5'd0) && (d == x);
   endfunction

   function automatic logic [1:0] fwd_sel(input logic [4:0] x,
                                          input logic       em_wr,
                                          input logic       em_m2r,
                                          input logic [4:0] em_rd,
                                          input logic       wb_wr,
                                          input logic [4:0] wb_rd);
      // A load in MEM has no aluout to forward yet; the hazard logic stalls instead.
      if (em_wr && !em_m2r && reg_match(em_rd, x)) return 2'b01;
      else if (wb_wr && reg_match(wb_rd, x))        return 2'b10;
      else                                          return 2'b00;
   endfunction

   always_comb begin
      forwardSignal[3:2] = fwd_sel(ID_Rs, EX_MEM_RegWrite, EX_MEM_Mem2Reg, EX_MEM_Rd,
                                   MEM_WB_RegWrite, MEM_WB_Rd);
      forwardSignal[1:0] = fwd_sel(ID_Rt, EX_MEM_RegWrite, EX_MEM_Mem2Reg, EX_MEM_Rd,
                                   MEM_WB_RegWrite, MEM_WB_Rd);
   end

   logic ex_dep, mem_dep, br_reads;

   always_comb begin
      ex_dep   = reg_match(ID_EX_Rd, ID_Rs) || reg_match(ID_EX_Rd, ID_Rt);
      mem_dep  = reg_match(EX_MEM_Rd, ID_Rs) || reg_match(EX_MEM_Rd, ID_Rt);
      br_reads = ID_Beq || ID_JumpV;
      hz = (ID_EX_RegWrite && ID_EX_Mem2Reg && ex_dep)
         | (br_reads && ID_EX_RegWrite && ex_dep)
         | (br_reads && EX_MEM_RegWrite && EX_MEM_Mem2Reg && mem_dep);
   end

   // Divider sequencer: the start cycle itself already stalls, then the
   // counter runs down to zero and the final cycle releases EX with div_done.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      dstall   = 1'b0;
      done_raw = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (EX_div_start) begin
               dstall  = 1'b1;
               cnt_d   = CNT_LOAD;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (cnt_q != '0) begin
               dstall = 1'b1;
               cnt_d  = cnt_q - CNT_W'(1);
            end else begin
               done_raw = 1'b1;
               state_d  = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
      // An exception in MEM kills the division in flight.
      if (exc_valid) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      flush      = exc_valid;
      stall      = !flush && (hz || dstall);
      stall_EX   = !flush && dstall;
      bubble_MEM = stall_EX;
      div_busy   = (state_q == ST_BUSY);
      div_done   = !flush && done_raw;
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed steps followed by randomized cycles, every cycle
// compared against a timestamp-based reference model of the hazard controller.
module tb_hazard_ctrl;

   localparam int D = 32;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] ID_Rs, ID_Rt;
   logic       ID_Beq, ID_JumpV;
   logic       ID_EX_RegWrite, ID_EX_Mem2Reg;
   logic [4:0] ID_EX_Rd;
   logic       EX_MEM_RegWrite, EX_MEM_Mem2Reg;
   logic [4:0] EX_MEM_Rd;
   logic       MEM_WB_RegWrite;
   logic [4:0] MEM_WB_Rd;
   logic       EX_div_start, exc_valid;
   logic [3:0] forwardSignal;
   logic       stall, stall_EX, bubble_MEM, flush, div_busy, div_done;

   int errors = 0;
   int checks = 0;

   // Reference model: cycle of the accepted division start, -1 when none.
   int cyc = 0;
   int div_t0 = -1;
   int done_seen = 0;
   int stall_seen = 0;

   always #5 clk = ~clk;

   hazard_ctrl #(.DIV_CYCLES(D), .CNT_W(6)) dut (
      .clk(clk), .rst(rst),
      .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Beq(ID_Beq), .ID_JumpV(ID_JumpV),
      .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_Mem2Reg(ID_EX_Mem2Reg), .ID_EX_Rd(ID_EX_Rd),
      .EX_MEM_RegWrite(EX_MEM_RegWrite), .EX_MEM_Mem2Reg(EX_MEM_Mem2Reg),
      .EX_MEM_Rd(EX_MEM_Rd),
      .MEM_WB_RegWrite(MEM_WB_RegWrite), .MEM_WB_Rd(MEM_WB_Rd),
      .EX_div_start(EX_div_start), .exc_valid(exc_valid),
      .forwardSignal(forwardSignal), .stall(stall), .stall_EX(stall_EX),
      .bubble_MEM(bubble_MEM), .flush(flush), .div_busy(div_busy), .div_done(div_done)
   );

   function automatic bit dep(input logic [4:0] d, input logic [4:0] x);
      return d != 0 && d == x;
   endfunction

   function automatic logic [1:0] m_fwd(input logic [4:0] x);
      if (EX_MEM_RegWrite && !EX_MEM_Mem2Reg && dep(EX_MEM_Rd, x)) return 2'b01;
      if (MEM_WB_RegWrite && dep(MEM_WB_Rd, x)) return 2'b10;
      return 2'b00;
   endfunction

   function automatic bit m_hz();
      bit reads_ex  = dep(ID_EX_Rd, ID_Rs) || dep(ID_EX_Rd, ID_Rt);
      bit reads_mem = dep(EX_MEM_Rd, ID_Rs) || dep(EX_MEM_Rd, ID_Rt);
      bit branch    = ID_Beq || ID_JumpV;
      if (ID_EX_RegWrite && ID_EX_Mem2Reg && reads_ex) return 1;
      if (branch && ID_EX_RegWrite && reads_ex) return 1;
      if (branch && EX_MEM_RegWrite && EX_MEM_Mem2Reg && reads_mem) return 1;
      return 0;
   endfunction

   task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic clear_inputs();
      ID_Rs = 0; ID_Rt = 0; ID_Beq = 0; ID_JumpV = 0;
      ID_EX_RegWrite = 0; ID_EX_Mem2Reg = 0; ID_EX_Rd = 0;
      EX_MEM_RegWrite = 0; EX_MEM_Mem2Reg = 0; EX_MEM_Rd = 0;
      MEM_WB_RegWrite = 0; MEM_WB_Rd = 0;
      EX_div_start = 0; exc_valid = 0;
   endtask

   // One cycle: inputs already set (clk low); compare, clock, advance model.
   task automatic step(input bit chk);
      bit active, m_dstall, m_done, m_busy, m_hzv;
      int el;
      #1;
      active = div_t0 >= 0;
      el     = cyc - div_t0;
      if (!active) begin
         m_dstall = EX_div_start; m_done = 0; m_busy = 0;
      end else begin
         m_dstall = el < D; m_done = el == D; m_busy = 1;
      end
      m_hzv = m_hz();
      if (chk) begin
         check("fwd", forwardSignal, {m_fwd(ID_Rs), m_fwd(ID_Rt)});
         check("flush", {3'b0, flush}, {3'b0, exc_valid});
         check("stall", {3'b0, stall}, {3'b0, !exc_valid && (m_hzv || m_dstall)});
         check("stall_EX", {3'b0, stall_EX}, {3'b0, !exc_valid && m_dstall});
         check("bubble_MEM", {3'b0, bubble_MEM}, {3'b0, !exc_valid && m_dstall});
         check("div_busy", {3'b0, div_busy}, {3'b0, m_busy});
         check("div_done", {3'b0, div_done}, {3'b0, m_done && !exc_valid});
         if (div_done === 1'b1) done_seen++;
         if (stall === 1'b1) stall_seen++;
      end
      @(posedge clk);
      if (rst || exc_valid)              div_t0 = -1;
      else if (!active && EX_div_start)  div_t0 = cyc;
      else if (active && el == D)        div_t0 = -1;
      cyc++;
      @(negedge clk);
   endtask

   initial begin
      clear_inputs();
      rst = 1;
      @(negedge clk);
      // Reset with random register fields, write enables low.
      ID_Rs = 5'($urandom); ID_Rt = 5'($urandom); ID_EX_Rd = 5'($urandom);
      step(0);
      ID_Rs = 5'($urandom); EX_MEM_Rd = 5'($urandom); MEM_WB_Rd = 5'($urandom);
      step(1);
      check("rst_all_zero", {stall, stall_EX, flush, div_busy}, 4'b0);
      rst = 0;
      clear_inputs();
      step(1);

      // Forwarding priority: EX/MEM wins over WB.
      ID_Rs = 5; EX_MEM_Rd = 5; EX_MEM_RegWrite = 1; MEM_WB_Rd = 5; MEM_WB_RegWrite = 1;
      #1 check("fwd_prio_rs", {2'b0, forwardSignal[3:2]}, 4'b0001);
      step(1);
      EX_MEM_RegWrite = 0;
      #1 check("fwd_wb_rs", {2'b0, forwardSignal[3:2]}, 4'b0010);
      step(1);

      // Register 0 never forwards or stalls.
      clear_inputs();
      ID_Beq = 1; ID_EX_RegWrite = 1; ID_EX_Mem2Reg = 1;
      EX_MEM_RegWrite = 1; EX_MEM_Mem2Reg = 1; MEM_WB_RegWrite = 1;
      #1 check("r0_fwd_rt", {2'b0, forwardSignal[1:0]}, 4'b0);
      check("r0_stall", {3'b0, stall}, 4'b0);
      step(1);

      // Load-use: one stall cycle, then the load in MEM no longer stalls.
      clear_inputs();
      stall_seen = 0;
      ID_Rt = 8; ID_EX_RegWrite = 1; ID_EX_Mem2Reg = 1; ID_EX_Rd = 8;
      step(1);
      ID_EX_RegWrite = 0; ID_EX_Mem2Reg = 0; ID_EX_Rd = 0;
      EX_MEM_RegWrite = 1; EX_MEM_Mem2Reg = 1; EX_MEM_Rd = 8;
      step(1);
      check("loaduse_len", 4'(stall_seen), 4'd1);

      // Branch on a load: stalls in EX and again in MEM, then forwards from WB.
      clear_inputs();
      stall_seen = 0;
      ID_Beq = 1; ID_Rt = 8; ID_EX_RegWrite = 1; ID_EX_Mem2Reg = 1; ID_EX_Rd = 8;
      step(1);
      ID_EX_RegWrite = 0; ID_EX_Mem2Reg = 0; ID_EX_Rd = 0;
      EX_MEM_RegWrite = 1; EX_MEM_Mem2Reg = 1; EX_MEM_Rd = 8;
      step(1);
      EX_MEM_RegWrite = 0; EX_MEM_Mem2Reg = 0; EX_MEM_Rd = 0;
      MEM_WB_RegWrite = 1; MEM_WB_Rd = 8;
      step(1);
      check("branch_load_len", 4'(stall_seen), 4'd2);

      // Divider: start held while EX is stalled, then released.
      clear_inputs();
      stall_seen = 0; done_seen = 0;
      EX_div_start = 1;
      for (int i = 0; i < D; i++) step(1);
      EX_div_start = 0;
      for (int i = 0; i < 4; i++) step(1);
      check("div_stall_len", 4'(stall_seen >> 3), 4'(D >> 3));
      check("div_done_cnt", 4'(done_seen), 4'd1);

      // Exception aborts the divider five cycles in.
      done_seen = 0;
      EX_div_start = 1;
      for (int i = 0; i < 5; i++) step(1);
      exc_valid = 1;
      step(1);
      exc_valid = 0; EX_div_start = 0;
      #1 check("exc_idle", {3'b0, div_busy}, 4'b0);
      for (int i = 0; i < D + 4; i++) step(1);
      check("exc_no_done", 4'(done_seen), 4'd0);

      // Randomized traffic on a small register set to provoke matches.
      for (int i = 0; i < 3000; i++) begin
         ID_Rs = 5'($urandom_range(0, 3)); ID_Rt = 5'($urandom_range(0, 3));
         ID_Beq = 1'($urandom_range(0, 3) == 0); ID_JumpV = 1'($urandom_range(0, 7) == 0);
         ID_EX_RegWrite = 1'($urandom); ID_EX_Mem2Reg = 1'($urandom);
         ID_EX_Rd = 5'($urandom_range(0, 3));
         EX_MEM_RegWrite = 1'($urandom); EX_MEM_Mem2Reg = 1'($urandom);
         EX_MEM_Rd = 5'($urandom_range(0, 3));
         MEM_WB_RegWrite = 1'($urandom); MEM_WB_Rd = 5'($urandom_range(0, 3));
         EX_div_start = 1'($urandom_range(0, 15) == 0);
         exc_valid = 1'($urandom_range(0, 59) == 0);
         rst = 1'($urandom_range(0, 299) == 0);
         step(1);
      end
      rst = 0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
